jump_ctrl: RTL
==============

Name: jump_ctrl

Overview:
- Branch/jump control unit that drives the program counter's jump interface: reljump_en, absjump_en and target.
- Takes the decoded control-flow op, the condition flag and a target-LUT index from the decoder, plus the current prog_ctr.
- Holds a writable target lookup table and a return-address stack, so CALL and RET are supported.
- Jump outputs are combinational, so the program counter acts on the edge that ends the current instruction's cycle.

Parameters:
- WIDTH, 12: program counter and target width in bits.
- LUT_DEPTH, 32: number of target LUT entries (power of 2).
- STACK_DEPTH, 4: return-address stack entries (power of 2, at least 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- op  input  3  decoded control-flow op (jump_pkg::op_t).
- cond_flag  input  1  branch condition from ALU/flag register.
- lut_idx  input  $clog2(LUT_DEPTH)  target LUT read index.
- prog_ctr  input  WIDTH  current PC value.
- lut_we  input  1  LUT write enable.
- lut_waddr  input  $clog2(LUT_DEPTH)  LUT write index.
- lut_wdata  input  WIDTH  LUT write data.
- reljump_en  output  1  relative jump request to PC.
- absjump_en  output  1  absolute jump request to PC.
- target  output  WIDTH  offset (relative) or address (absolute).
- stack_empty  output  1  return stack holds no entries.
- stack_full  output  1  return stack holds STACK_DEPTH entries.
- err  output  1  sticky error flag.
- err_code  output  2  first error cause (jump_pkg::err_t).

Behaviour:
- Reset (synchronous, priority over everything):
  - All LUT entries and stack entries cleared to 0.
  - Stack pointer = 0, so stack_empty=1 and stack_full=0.
  - err=0, err_code=ERR_NONE.
  - Jump outputs follow the op decode below. While reset is asserted the PC's own reset dominates.
- Op decode (combinational, zero latency). Default for every op is reljump_en=0, absjump_en=0, target=0.
  - 0 NONE: defaults only.
  - 1 BR_REL: if cond_flag, reljump_en=1 and target=LUT[lut_idx]. The entry is a two's-complement offset; the PC wraps mod 2^WIDTH.
  - 2 JMP_ABS: absjump_en=1, target=LUT[lut_idx].
  - 3 CALL: if not full, absjump_en=1, target=LUT[lut_idx], and at the clock edge push prog_ctr+1 (wraps mod 2^WIDTH).
  - 4 RET: if not empty, absjump_en=1, target=top of stack, and at the clock edge pop.
  - 5 BR_ABS: if cond_flag, absjump_en=1, target=LUT[lut_idx].
  - 6-7: reserved, treated as NONE and raise ERR_ILLEGAL.
- reljump_en and absjump_en are never both 1.
- Boundary conditions:
  - CALL when full: no push, no jump (PC falls through), raise ERR_OVERFLOW.
  - RET when empty: no pop, no jump, raise ERR_UNDERFLOW.
  - err is set on the first error; err_code records that first cause and holds it until reset. Later errors do not overwrite it.
  - LUT write and read of the same index in one cycle: the read returns the old value; the new value is visible next cycle.
  - LUT writes are independent of op processing and may occur in any cycle.
  - cond_flag is ignored for ops 2-4.
  - The stack never wraps: the pointer saturates at 0 and STACK_DEPTH.

Optional Feature:
- Macro JUMP_CTRL_PERF_EN.
- When defined, two extra outputs are added:
  - taken_cnt (16 bits): counts cycles in which reljump_en or absjump_en is 1.
  - not_taken_cnt (16 bits): counts BR_REL/BR_ABS ops with cond_flag=0.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and their registers do not exist and all other behaviour is identical.

Decomposition:
- jump_pkg holds:
  - op_t enum: NONE, BR_REL, JMP_ABS, CALL, RET, BR_ABS.
  - err_t enum: ERR_NONE, ERR_ILLEGAL, ERR_OVERFLOW, ERR_UNDERFLOW.
  - Op-width constant.
- Sub-module ret_stack (push, pop, top, empty, full; parameterized on WIDTH and STACK_DEPTH).
- The LUT stays inline in jump_ctrl.

Test Plan:
- Reset, then write LUT[3]=12'h040 → next cycle op=JMP_ABS, lut_idx=3 → absjump_en=1, target=12'h040, reljump_en=0.
- LUT[5]=12'hFFC, op=BR_REL: cond_flag=1 → reljump_en=1, target=12'hFFC; cond_flag=0 → both enables 0.
- prog_ctr=12'h010, CALL with LUT[1]=12'h200 → absjump_en=1, target=12'h200. Next, RET → absjump_en=1, target=12'h011, stack_empty=1.
- 4 CALLs → stack_full=1; 5th CALL → no jump, err=1, err_code=ERR_OVERFLOW. A later RET on empty stack leaves err_code=ERR_OVERFLOW.
- op=6 → both enables 0, err=1, err_code=ERR_ILLEGAL. Assert reset → err=0, stack_empty=1.
- Same-cycle LUT write 12'h123 and BR_ABS read of index 7 → target is the old value; the next cycle shows 12'h123.

Source files
------------

// File: rtl/jump_pkg.sv
// Shared types for the branch/jump control unit: control-flow ops and error causes.
package jump_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        NONE    = 3'd0,
        BR_REL  = 3'd1,
        JMP_ABS = 3'd2,
        CALL    = 3'd3,
        RET     = 3'd4,
        BR_ABS  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_ILLEGAL   = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } err_t;

endpackage

// File: rtl/jump_ctrl_ret_stack.sv
// Saturating return-address stack; the pointer never wraps past 0 or DEPTH.
module ret_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;

    assign empty = (ptr_q == '0);
    assign full  = (ptr_q == PW'(DEPTH));

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (PW'(i + 1) == ptr_q) top = mem_q[i];
        end
    end

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (PW'(i) == ptr_q) mem_d[i] = push_data;
            end
            ptr_d = ptr_q + PW'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Branch/jump control: target LUT, return stack and combinational PC jump requests.
// Define JUMP_CTRL_PERF_EN to add taken/not-taken saturating counters.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int LUT_DEPTH   = 32,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [OP_W-1:0]              op,
    input  logic                         cond_flag,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_idx,
    input  logic [WIDTH-1:0]             prog_ctr,
    input  logic                         lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
    input  logic [WIDTH-1:0]             lut_wdata,
    output logic                         reljump_en,
    output logic                         absjump_en,
    output logic [WIDTH-1:0]             target,
    output logic                         stack_empty,
    output logic                         stack_full,
    output logic                         err,
    output logic [1:0]                   err_code
`ifdef JUMP_CTRL_PERF_EN
    ,
    output logic [15:0]                  taken_cnt,
    output logic [15:0]                  not_taken_cnt
`endif
);

    logic [WIDTH-1:0] lut_q [LUT_DEPTH];
    logic [WIDTH-1:0] lut_d [LUT_DEPTH];
    logic [WIDTH-1:0] lut_rd;
    logic [WIDTH-1:0] stk_top;
    logic             push;
    logic             pop;
    logic             err_now;
    err_t             cause;
    logic             err_q;
    logic             err_d;
    err_t             err_code_q;
    err_t             err_code_d;

    // Read sees the pre-write contents; writes land at the edge.
    assign lut_rd = lut_q[lut_idx];

    always_comb begin
        lut_d = lut_q;
        if (lut_we) lut_d[lut_waddr] = lut_wdata;
    end

    always_comb begin
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        target     = '0;
        push       = 1'b0;
        pop        = 1'b0;
        err_now    = 1'b0;
        cause      = ERR_NONE;
        case (op)
            NONE: ;
            BR_REL: if (cond_flag) begin
                reljump_en = 1'b1;
                target     = lut_rd;
            end
            JMP_ABS: begin
                absjump_en = 1'b1;
                target     = lut_rd;
            end
            CALL: if (!stack_full) begin
                absjump_en = 1'b1;
                target     = lut_rd;
                push       = 1'b1;
            end else begin
                err_now = 1'b1;
                cause   = ERR_OVERFLOW;
            end
            RET: if (!stack_empty) begin
                absjump_en = 1'b1;
                target     = stk_top;
                pop        = 1'b1;
            end else begin
                err_now = 1'b1;
                cause   = ERR_UNDERFLOW;
            end
            BR_ABS: if (cond_flag) begin
                absjump_en = 1'b1;
                target     = lut_rd;
            end
            default: begin
                err_now = 1'b1;
                cause   = ERR_ILLEGAL;
            end
        endcase
    end

    // Only the first error is recorded; it sticks until reset.
    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        if (err_now && !err_q) begin
            err_d      = 1'b1;
            err_code_d = cause;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lut_q      <= '{default: '0};
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            lut_q      <= lut_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (prog_ctr + WIDTH'(1)),
        .top       (stk_top),
        .empty     (stack_empty),
        .full      (stack_full)
    );

`ifdef JUMP_CTRL_PERF_EN
    logic [15:0] taken_q;
    logic [15:0] taken_d;
    logic [15:0] nt_q;
    logic [15:0] nt_d;
    logic        is_br;

    assign is_br = (op == BR_REL) || (op == BR_ABS);

    always_comb begin
        taken_d = taken_q;
        nt_d    = nt_q;
        if ((reljump_en || absjump_en) && taken_q != 16'hFFFF)
            taken_d = taken_q + 16'd1;
        if (is_br && !cond_flag && nt_q != 16'hFFFF)
            nt_d = nt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q <= '0;
            nt_q    <= '0;
        end else begin
            taken_q <= taken_d;
            nt_q    <= nt_d;
        end
    end

    assign taken_cnt     = taken_q;
    assign not_taken_cnt = nt_q;
`endif

endmodule
